// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for one shared 4:1 mux/decoder.
// Requesters 0..3 compete for the mux. The owner keeps it for at most HOLD
// consecutive cycles. Every hand-over goes through one GAP cycle with the
// enable low, so there is always a break before a new owner takes the mux.
// All outputs are registered and none depends combinationally on req.
module mux4_rr_arbiter #(
  parameter int unsigned HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:3] req,
  output logic [1:0] S,
  output logic       En,
  output logic [0:3] gnt,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // The owner is released on the edge that ends its HOLD-th grant cycle.
  localparam logic [3:0] CNT_LAST = 4'(HOLD - 1);

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q,  last_d;
  logic [3:0] cnt_q,   cnt_d;
  logic       en_q,    en_d;
  logic [0:3] gnt_q,   gnt_d;
  logic       busy_q,  busy_d;
  logic [2:0] pick;

  // Round-robin search order: last+1, last+2, last+3 and finally last.
  // The result is {found, index}. The 2-bit index add wraps modulo 4.
  function automatic logic [2:0] rr_pick(input logic [0:3] r, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!rr_pick[2] && r[idx]) begin
        rr_pick = {1'b1, idx};
      end
    end
  endfunction

  assign pick = rr_pick(req, last_q);

  // State, ownership and output registers. Reset is asynchronous, so En and
  // gnt drop immediately. last starts at 3, which gives requester 0 the
  // highest priority for the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= 4'd0;
      en_q    <= 1'b0;
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  // Next state: arbitrate from IDLE or GAP, release on request drop or when
  // the hold budget is used up, and always pass through GAP between owners.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick[2]) begin
          state_d = ST_GRANT;
          owner_d = pick[1:0];
          last_d  = pick[1:0];
          cnt_d   = 4'd0;
        end
      end
      ST_GRANT: begin
        if (!req[owner_q] || (cnt_q == CNT_LAST)) begin
          state_d = ST_GAP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_GAP: begin
        if (pick[2]) begin
          state_d = ST_GRANT;
          owner_d = pick[1:0];
          last_d  = pick[1:0];
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output decode of the upcoming state. This keeps every output a flop
  // while it still lines up with the state it describes. Only GRANT drives a
  // one-hot grant and the enable.
  always_comb begin
    en_d   = (state_d == ST_GRANT);
    busy_d = (state_d != ST_IDLE);
    gnt_d  = 4'b0000;
    if (state_d == ST_GRANT) begin
      gnt_d[owner_d] = 1'b1;
    end
  end

  // S follows the owner and holds its value through GAP and IDLE.
  assign S    = owner_q;
  assign En   = en_q;
  assign gnt  = gnt_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter (HOLD = 4). Each step pushes the
// expected post-edge outputs to a scoreboard queue, applies req, and pops
// and compares once the edge has passed. Each sample also checks the grant
// invariants and logs the cycle.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [0:3] req;
  logic [1:0] S;
  logic       En;
  logic [0:3] gnt;
  logic       busy;

  typedef struct packed {
    logic [1:0] s;
    logic       en;
    logic [0:3] g;
    logic       b;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  mux4_rr_arbiter #(.HOLD(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .S    (S),
    .En   (En),
    .gnt  (gnt),
    .busy (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [0:3] oh(input logic [1:0] k);
    oh = 4'b0000;
    oh[k] = 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic compare(input string tag, input exp_t e);
    $display("%0t req=%b S=%0d En=%b gnt=%b busy=%b", $time, req, S, En, gnt, busy);
    chk({tag, "/S"},    {2'b00, S},    {2'b00, e.s});
    chk({tag, "/En"},   {3'b000, En},  {3'b000, e.en});
    chk({tag, "/gnt"},  gnt,           e.g);
    chk({tag, "/busy"}, {3'b000, busy}, {3'b000, e.b});
    chk({tag, "/inv_onehot0"}, {3'b000, $onehot0(gnt)}, 4'b0001);
    chk({tag, "/inv_en_or"},   {3'b000, En}, {3'b000, |gnt});
    chk({tag, "/inv_sel"},     {3'b000, (En ? gnt[S] : 1'b1)}, 4'b0001);
  endtask

  // Drive req, then check the outputs one clock edge later.
  task automatic step(input logic [0:3] r, input exp_t e, input string tag);
    exp_t got;
    req = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    compare(tag, got);
  endtask

  // Check the outputs at the current time, with no clock edge in between.
  task automatic check_now(input exp_t e, input string tag);
    exp_t got;
    sb.push_back(e);
    got = sb.pop_front();
    compare(tag, got);
  endtask

  function automatic exp_t x_grant(input logic [1:0] o);
    x_grant = '{s: o, en: 1'b1, g: oh(o), b: 1'b1};
  endfunction

  function automatic exp_t x_gap(input logic [1:0] o);
    x_gap = '{s: o, en: 1'b0, g: 4'b0000, b: 1'b1};
  endfunction

  function automatic exp_t x_idle(input logic [1:0] o);
    x_idle = '{s: o, en: 1'b0, g: 4'b0000, b: 1'b0};
  endfunction

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;

    // Reset state, checked before any clock edge.
    #3;
    check_now(x_idle(2'd0), "reset_async");
    @(posedge clk);
    #1;
    check_now(x_idle(2'd0), "reset_held_edge");
    #2;
    rst_n = 1'b1;
    #1;
    check_now(x_idle(2'd0), "reset_release");
    step(4'b0000, x_idle(2'd0), "idle_noreq");

    // Sole requester 0: four grant cycles, one GAP cycle, then a re-grant.
    for (int c = 0; c < 4; c++) step(4'b1000, x_grant(2'd0), "solo0_grant");
    step(4'b1000, x_gap(2'd0),   "solo0_gap");
    step(4'b1000, x_grant(2'd0), "solo0_regrant");
    step(4'b0000, x_gap(2'd0),   "solo0_drop_gap");
    step(4'b0000, x_idle(2'd0),  "solo0_idle");

    // From IDLE, req=0001 gives S=3 one edge later. S then holds at 3 in IDLE.
    step(4'b0001, x_grant(2'd3), "r3_grant");
    step(4'b0000, x_gap(2'd3),   "r3_gap");
    step(4'b0000, x_idle(2'd3),  "r3_idle_hold");

    // All four requesting: rotation 0,1,2,3,0 with a GAP after every owner.
    for (int o = 0; o < 4; o++) begin
      for (int c = 0; c < 4; c++) step(4'b1111, x_grant(2'(o)), "all_grant");
      step(4'b1111, x_gap(2'(o)), "all_gap");
    end
    for (int c = 0; c < 4; c++) step(4'b1111, x_grant(2'd0), "all_wrap0");
    step(4'b0000, x_gap(2'd0),  "all_end_gap");
    step(4'b0000, x_idle(2'd0), "all_end_idle");

    // Owner 2 drops its request early. Requester 0 takes over and is not
    // preempted when 2 asks again. Requester 2 wins at the next GAP.
    step(4'b1010, x_grant(2'd2), "drop_own2_c0");
    step(4'b1010, x_grant(2'd2), "drop_own2_c1");
    step(4'b1000, x_gap(2'd2),   "drop_gap");
    step(4'b1000, x_grant(2'd0), "drop_own0_c0");
    for (int c = 0; c < 3; c++) step(4'b1010, x_grant(2'd0), "nopreempt_own0");
    step(4'b1010, x_gap(2'd0),   "own0_hold_gap");
    step(4'b1010, x_grant(2'd2), "own2_again");
    step(4'b0000, x_gap(2'd2),   "own2_rel_gap");
    step(4'b0000, x_idle(2'd2),  "own2_rel_idle");

    // Reset in the middle of owner 1's grant. After release, owner 0 wins first.
    step(4'b0100, x_grant(2'd1), "rst_own1_c0");
    step(4'b0100, x_grant(2'd1), "rst_own1_c1");
    #3;
    rst_n = 1'b0;
    #1;
    check_now(x_idle(2'd0), "rst_mid_grant");
    req = 4'b1111;
    @(posedge clk);
    #1;
    check_now(x_idle(2'd0), "rst_hold_req");
    #2;
    rst_n = 1'b1;
    #1;
    check_now(x_idle(2'd0), "rst_rel_noedge");
    step(4'b1111, x_grant(2'd0), "rst_first_own0");
    step(4'b1111, x_grant(2'd0), "rst_own0_c1");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
